// File: rtl/ring_pkg.sv
// Shared packet layout, port enumeration and field helpers for the bidirectional ring node.
package ring_pkg;

    localparam int DW      = 64;
    localparam int VC_BIT  = 63;
    localparam int DIR_BIT = 62;
    localparam int HOP_MSB = 55;
    localparam int HOP_LSB = 48;
    localparam int SRC_MSB = 47;
    localparam int SRC_LSB = 32;

    typedef logic [DW-1:0] pkt_t;

    typedef enum logic [1:0] {
        PORT_CW  = 2'd0,
        PORT_CCW = 2'd1,
        PORT_PE  = 2'd2
    } port_e;

    // One hop consumed: the hop field shifts right by one.
    function automatic pkt_t hop_shift(input pkt_t pkt);
        pkt_t res;
        res = pkt;
        res[HOP_MSB:HOP_LSB] = {1'b0, pkt[HOP_MSB:HOP_LSB+1]};
        return res;
    endfunction

endpackage

// File: rtl/ring_rr_arb2.sv
// Two-requester round-robin arbiter; pointer moves past the winner when en qualifies a grant.
module ring_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic ptr_r;

    // Grant selection: ptr_r=0 gives requester 0 priority.
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!ptr_r || !req[1])) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end else begin
            gnt = 2'b00;
        end
    end

    // Priority pointer update on a qualified grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 1'b0;
        end else if (en && (gnt != 2'b00)) begin
            ptr_r <= gnt[0];
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/ring_node_router.sv
// One node of the 4-node bidirectional ring: cw, ccw and PE ports, two time-shared virtual channels.
module ring_node_router #(
    parameter int DW      = 64,
    parameter int HOP_LSB = 48
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cwsi,
    output logic          cwri,
    input  logic [DW-1:0] cwdi,
    input  logic          ccwsi,
    output logic          ccwri,
    input  logic [DW-1:0] ccwdi,
    output logic          cwso,
    input  logic          cwro,
    output logic [DW-1:0] cwdo,
    output logic          ccwso,
    input  logic          ccwro,
    output logic [DW-1:0] ccwdo,
    input  logic          pesi,
    output logic          peri,
    input  logic [DW-1:0] pedi,
    output logic          peso,
    input  logic          pero,
    output logic [DW-1:0] pedo,
    output logic          polarity
);

    import ring_pkg::*;

    logic          polarity_r;
    logic [1:0]    in_full_r  [3];
    logic [1:0]    out_full_r [3];
    logic [DW-1:0] in_data_r  [3][2];
    logic [DW-1:0] out_data_r [3][2];

    logic          p_s;
    logic          q_s;
    logic [2:0]    si_s;
    logic [2:0]    ro_s;
    logic [2:0]    ri_s;
    logic [2:0]    acc_s;
    logic [2:0]    so_s;
    logic [2:0]    out_pop_s;
    logic [2:0]    in_pop_s;
    logic [2:0]    push_s;
    logic [DW-1:0] din_s       [3];
    logic [DW-1:0] out_do_s    [3];
    logic [DW-1:0] pk_s        [3];
    logic [DW-1:0] push_data_s [3];
    logic [1:0]    route_req_s [3];
    logic [1:0]    arb_req_s   [3][2];
    logic [1:0]    arb_en_s    [3];
    logic [1:0]    arb_gnt_s   [3][2];
    logic [1:0]    gq_s        [3];

    // p is the external (link/PE) VC this cycle, q the internal (move) VC.
    assign p_s = polarity_r;
    assign q_s = ~polarity_r;

    // Port bundling into indexable vectors.
    always_comb begin
        si_s            = {pesi, ccwsi, cwsi};
        ro_s            = {pero, ccwro, cwro};
        din_s[PORT_CW]  = cwdi;
        din_s[PORT_CCW] = ccwdi;
        din_s[PORT_PE]  = pedi;
    end

    // External phase: accept into VC p inputs, present VC p outputs.
    always_comb begin
        ri_s      = 3'b000;
        acc_s     = 3'b000;
        so_s      = 3'b000;
        out_pop_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            ri_s[i]      = ~in_full_r[i][p_s];
            acc_s[i]     = si_s[i] & ~in_full_r[i][p_s];
            so_s[i]      = out_full_r[i][p_s];
            out_pop_s[i] = out_full_r[i][p_s] & ro_s[i];
            out_do_s[i]  = out_full_r[i][p_s] ? out_data_r[i][p_s] : {DW{1'b0}};
        end
    end

    // Internal phase requests: req[0] is the ring-forward source, req[1] the other.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            pk_s[i] = in_data_r[i][q_s];
        end
        route_req_s[PORT_PE]  = {in_full_r[PORT_CCW][q_s] &  pk_s[PORT_CCW][HOP_LSB],
                                 in_full_r[PORT_CW][q_s]  &  pk_s[PORT_CW][HOP_LSB]};
        route_req_s[PORT_CW]  = {in_full_r[PORT_PE][q_s]  & ~pk_s[PORT_PE][DIR_BIT],
                                 in_full_r[PORT_CW][q_s]  & ~pk_s[PORT_CW][HOP_LSB]};
        route_req_s[PORT_CCW] = {in_full_r[PORT_PE][q_s]  &  pk_s[PORT_PE][DIR_BIT],
                                 in_full_r[PORT_CCW][q_s] & ~pk_s[PORT_CCW][HOP_LSB]};
        for (int o = 0; o < 3; o++) begin
            for (int v = 0; v < 2; v++) begin
                arb_en_s[o][v]  = ~out_full_r[o][q_s] & (q_s == v[0]);
                arb_req_s[o][v] = arb_en_s[o][v] ? route_req_s[o] : 2'b00;
            end
        end
    end

    genvar go, gv;
    generate
        for (go = 0; go < 3; go++) begin : g_out
            for (gv = 0; gv < 2; gv++) begin : g_vc
                ring_rr_arb2 u_arb (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .req   (arb_req_s[go][gv]),
                    .en    (arb_en_s[go][gv]),
                    .gnt   (arb_gnt_s[go][gv])
                );
            end
        end
    endgenerate

    // Move decode: source pops, destination pushes with the routed packet.
    always_comb begin
        for (int o = 0; o < 3; o++) begin
            gq_s[o]   = arb_gnt_s[o][0] | arb_gnt_s[o][1];
            push_s[o] = |gq_s[o];
        end
        in_pop_s[PORT_CW]  = gq_s[PORT_PE][0] | gq_s[PORT_CW][0];
        in_pop_s[PORT_CCW] = gq_s[PORT_PE][1] | gq_s[PORT_CCW][0];
        in_pop_s[PORT_PE]  = gq_s[PORT_CW][1] | gq_s[PORT_CCW][1];
        push_data_s[PORT_PE]  = gq_s[PORT_PE][0]  ? pk_s[PORT_CW] : pk_s[PORT_CCW];
        push_data_s[PORT_CW]  = gq_s[PORT_CW][0]  ? hop_shift(pk_s[PORT_CW])  : pk_s[PORT_PE];
        push_data_s[PORT_CCW] = gq_s[PORT_CCW][0] ? hop_shift(pk_s[PORT_CCW]) : pk_s[PORT_PE];
    end

    // Buffer state: VC p touched by link transfers, VC q by moves, never both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            polarity_r <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                in_full_r[i]  <= 2'b00;
                out_full_r[i] <= 2'b00;
                for (int v = 0; v < 2; v++) begin
                    in_data_r[i][v]  <= {DW{1'b0}};
                    out_data_r[i][v] <= {DW{1'b0}};
                end
            end
        end else begin
            polarity_r <= q_s;
            for (int i = 0; i < 3; i++) begin
                if (acc_s[i]) begin
                    in_full_r[i][p_s] <= 1'b1;
                    in_data_r[i][p_s] <= {p_s, din_s[i][DW-2:0]};
                end
                if (in_pop_s[i]) begin
                    in_full_r[i][q_s] <= 1'b0;
                end
                if (out_pop_s[i]) begin
                    out_full_r[i][p_s] <= 1'b0;
                end
                if (push_s[i]) begin
                    out_full_r[i][q_s] <= 1'b1;
                    out_data_r[i][q_s] <= push_data_s[i];
                end
            end
        end
    end

    assign cwri     = ri_s[PORT_CW];
    assign ccwri    = ri_s[PORT_CCW];
    assign peri     = ri_s[PORT_PE];
    assign cwso     = so_s[PORT_CW];
    assign ccwso    = so_s[PORT_CCW];
    assign peso     = so_s[PORT_PE];
    assign cwdo     = out_do_s[PORT_CW];
    assign ccwdo    = out_do_s[PORT_CCW];
    assign pedo     = out_do_s[PORT_PE];
    assign polarity = polarity_r;

endmodule

// File: tb/tb_ring_node_router.sv
// Directed table-driven bench for a single ring node plus contention, backpressure and reset sequences.
module tb_ring_node_router;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cwsi = 1'b0, ccwsi = 1'b0, pesi = 1'b0;
    logic [63:0] cwdi = 64'h0, ccwdi = 64'h0, pedi = 64'h0;
    logic        cwro = 1'b1, ccwro = 1'b1, pero = 1'b1;
    logic        cwri, ccwri, peri, cwso, ccwso, peso, polarity;
    logic [63:0] cwdo, ccwdo, pedo;

    ring_node_router #(.DW(64), .HOP_LSB(48)) dut (
        .clk(clk), .rst_n(rst_n),
        .cwsi(cwsi), .cwri(cwri), .cwdi(cwdi),
        .ccwsi(ccwsi), .ccwri(ccwri), .ccwdi(ccwdi),
        .cwso(cwso), .cwro(cwro), .cwdo(cwdo),
        .ccwso(ccwso), .ccwro(ccwro), .ccwdo(ccwdo),
        .pesi(pesi), .peri(peri), .pedi(pedi),
        .peso(peso), .pero(pero), .pedo(pedo),
        .polarity(polarity)
    );

    always #5 clk = ~clk;

    // Reference phase: starts at 0 out of reset and flips every edge.
    logic tb_ph;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ph <= 1'b0;
        else        tb_ph <= ~tb_ph;
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        mon_en = 1'b0;
    int          so_cnt = 0;
    logic [63:0] pe_q[$];

    // Delivery monitor, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (peso && pero) pe_q.push_back(pedo);
            if (cwso || ccwso || peso) so_cnt++;
        end
    end

    typedef struct {
        int          src;
        logic        vc;
        logic [63:0] din;
        int          dst;
        logic [63:0] dout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic align(input logic vc);
        for (int t = 0; t < 2 && tb_ph != vc; t++) tick();
    endtask

    task automatic inject(input logic [2:0] mask, input logic [63:0] dcw, input logic [63:0] dccw,
                          input logic [63:0] dpe);
        cwsi = mask[0]; ccwsi = mask[1]; pesi = mask[2];
        cwdi = dcw; ccwdi = dccw; pedi = dpe;
        tick();
        cwsi = 1'b0; ccwsi = 1'b0; pesi = 1'b0;
    endtask

    task automatic send_cw(input logic [63:0] pkt, output logic acc, output logic ph);
        acc = 1'b0;
        ph  = 1'b0;
        cwsi = 1'b1;
        cwdi = pkt;
        for (int t = 0; t < 8 && !acc; t++) begin
            if (cwri) begin
                acc = 1'b1;
                ph  = tb_ph;
            end
            tick();
        end
        cwsi = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [63:0] do_of(input int port);
        case (port)
            0:       return cwdo;
            1:       return ccwdo;
            default: return pedo;
        endcase
    endfunction

    function automatic logic ri_of(input int port);
        case (port)
            0:       return cwri;
            1:       return ccwri;
            default: return peri;
        endcase
    endfunction

    initial begin
        logic [63:0] exp0[$];
        logic [63:0] exp1[$];
        logic [63:0] got0[$];
        logic [63:0] got1[$];
        logic [63:0] pkt;
        logic [2:0]  mask;
        logic        acc, ph;

        // src/dst: 0=cw 1=ccw 2=pe; vc is the phase at acceptance
        vecs[0] = '{2, 1'b0, 64'h0001_0100_0000_00AA, 0, 64'h0001_0100_0000_00AA};
        vecs[1] = '{2, 1'b1, 64'h4002_0200_1234_5678, 1, 64'hC002_0200_1234_5678};
        vecs[2] = '{0, 1'b0, 64'h0001_0300_DEAD_BEEF, 2, 64'h0001_0300_DEAD_BEEF};
        vecs[3] = '{0, 1'b0, 64'h0004_0400_0000_0011, 0, 64'h0002_0400_0000_0011};
        vecs[4] = '{1, 1'b1, 64'h4003_0500_CAFE_F00D, 2, 64'hC003_0500_CAFE_F00D};
        vecs[5] = '{1, 1'b0, 64'hC0FE_0600_0000_0022, 1, 64'h407F_0600_0000_0022};
        vecs[6] = '{0, 1'b1, 64'h0000_0700_0000_0033, 0, 64'h8000_0700_0000_0033};
        vecs[7] = '{2, 1'b0, 64'h8080_0800_0000_0044, 0, 64'h0080_0800_0000_0044};

        #2 rst_n = 1'b0;
        #1;
        check("rst_so", {61'h0, peso, ccwso, cwso}, 64'h0);
        check("rst_ri", {61'h0, peri, ccwri, cwri}, 64'h7);
        check("rst_polarity", {63'h0, polarity}, 64'h0);
        check("rst_data", cwdo | ccwdo | pedo, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            align(vecs[i].vc);
            check($sformatf("vec%0d_polarity", i), {63'h0, polarity}, {63'h0, vecs[i].vc});
            check($sformatf("vec%0d_ri", i), {63'h0, ri_of(vecs[i].src)}, 64'h1);
            mask = 3'b001 << vecs[i].src;
            inject(mask, vecs[i].din, vecs[i].din, vecs[i].din);
            tick();
            mask = 3'b001 << vecs[i].dst;
            check($sformatf("vec%0d_so", i), {61'h0, peso, ccwso, cwso}, {61'h0, mask});
            check($sformatf("vec%0d_data", i), do_of(vecs[i].dst), vecs[i].dout);
            repeat (2) tick();
            check($sformatf("vec%0d_drain", i), {61'h0, peso, ccwso, cwso}, 64'h0);
        end

        // Contention on the PE output: cw wins first out of reset, then the pointer rotates.
        do_reset();
        align(1'b0);
        pe_q.delete();
        mon_en = 1'b1;
        inject(3'b011, 64'h0001_0A00_0000_0001, 64'h0001_0B00_0000_0002, 64'h0);
        repeat (8) tick();
        mon_en = 1'b0;
        check("t4a_count", 64'(pe_q.size()), 64'd2);
        check("t4a_first", (pe_q.size() > 0) ? pe_q[0] : 64'h0, 64'h0001_0A00_0000_0001);
        check("t4a_second", (pe_q.size() > 1) ? pe_q[1] : 64'h0, 64'h0001_0B00_0000_0002);
        align(1'b0);
        pe_q.delete();
        mon_en = 1'b1;
        inject(3'b001, 64'h0001_0C00_0000_0003, 64'h0, 64'h0);
        repeat (8) tick();
        mon_en = 1'b0;
        check("t4b_lone", (pe_q.size() == 1) ? pe_q[0] : 64'h0, 64'h0001_0C00_0000_0003);
        align(1'b0);
        pe_q.delete();
        mon_en = 1'b1;
        inject(3'b011, 64'h0001_0D00_0000_0004, 64'h0001_0E00_0000_0005, 64'h0);
        repeat (8) tick();
        mon_en = 1'b0;
        check("t4c_count", 64'(pe_q.size()), 64'd2);
        check("t4c_first", (pe_q.size() > 0) ? pe_q[0] : 64'h0, 64'h0001_0E00_0000_0005);
        check("t4c_second", (pe_q.size() > 1) ? pe_q[1] : 64'h0, 64'h0001_0D00_0000_0004);

        // Backpressure: four eject-bound packets fill both VCs of the cw input and PE output.
        pero = 1'b0;
        align(1'b0);
        for (int k = 0; k < 4; k++) begin
            pkt = 64'h0001_0900_5000_0000 | 64'(k);
            send_cw(pkt, acc, ph);
            check($sformatf("t5_accept%0d", k), {63'h0, acc}, 64'h1);
            if (ph) exp1.push_back({1'b1, pkt[62:0]});
            else    exp0.push_back({1'b0, pkt[62:0]});
        end
        check("t5_ri_phase_a", {63'h0, cwri}, 64'h0);
        tick();
        check("t5_ri_phase_b", {63'h0, cwri}, 64'h0);
        repeat (3) tick();
        check("t5_ri_held", {63'h0, cwri}, 64'h0);
        pe_q.delete();
        pero = 1'b1;
        mon_en = 1'b1;
        repeat (12) tick();
        mon_en = 1'b0;
        foreach (pe_q[j]) begin
            if (pe_q[j][63]) got1.push_back(pe_q[j]);
            else             got0.push_back(pe_q[j]);
        end
        check("t5_total", 64'(pe_q.size()), 64'd4);
        check("t5_vc0_count", 64'(got0.size()), 64'(exp0.size()));
        check("t5_vc1_count", 64'(got1.size()), 64'(exp1.size()));
        foreach (exp0[j]) check($sformatf("t5_vc0_%0d", j), (j < got0.size()) ? got0[j] : 64'h0, exp0[j]);
        foreach (exp1[j]) check($sformatf("t5_vc1_%0d", j), (j < got1.size()) ? got1[j] : 64'h0, exp1[j]);

        // Asynchronous reset with packets sitting in output buffers.
        align(1'b0);
        inject(3'b101, 64'h0004_0F00_0000_0066, 64'h0, 64'h4001_0F00_0000_0077);
        tick();
        #3 rst_n = 1'b0;
        #1;
        check("t6_so", {61'h0, peso, ccwso, cwso}, 64'h0);
        check("t6_ri", {61'h0, peri, ccwri, cwri}, 64'h7);
        check("t6_polarity", {63'h0, polarity}, 64'h0);
        check("t6_data", cwdo | ccwdo | pedo, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        so_cnt = 0;
        mon_en = 1'b1;
        repeat (10) tick();
        mon_en = 1'b0;
        check("t6_no_stale", 64'(so_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
